// File: rtl/clock_sequencer.sv
// clock_sequencer
//   Gates the processor clock-enable for board bring-up and debug. Everything
//   runs on inclk. proc_ce is a one-inclk-wide enable pulse. The four modes
//   are free-run at inclk/DIV, single-step from a push button, N-cycle burst,
//   and halt on processor request.
//
// Parameters
//   DIV    inclk cycles per processor cycle in RUN/BURST (>= 2)
//   BL_W   width of burst length / remaining-burst counter
//   CNT_W  width of executed-cycle counter
//
// Ports
//   inclk       in   board clock
//   rst         in   synchronous active-high reset
//   run_sw      in   level, requests free-run
//   step_btn    in   raw push button, asynchronous to inclk
//   burst_go    in   one-cycle pulse, starts a burst of burst_len cycles
//   burst_len   in   burst length, sampled when burst_go is accepted
//   halt_req    in   level from processor, highest priority outside HALT
//   clr_halt    in   one-cycle pulse, leaves HALT once halt_req is low
//   proc_ce     out  registered processor clock-enable pulse
//   state       out  IDLE=0 RUN=1 BURST=2 STEP=3 HALT=4
//   halted      out  registered, high while in HALT
//   burst_left  out  remaining burst cycles
//   cycle_cnt   out  proc_ce pulses issued, wraps silently
module clock_sequencer #(
  parameter int unsigned DIV   = 28'd50000000,
  parameter int unsigned BL_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             inclk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             burst_go,
  input  logic [BL_W-1:0]  burst_len,
  input  logic             halt_req,
  input  logic             clr_halt,
  output logic             proc_ce,
  output logic [2:0]       state,
  output logic             halted,
  output logic [BL_W-1:0]  burst_left,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_BURST = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  pre_q, pre_d;
  logic             ce_q, ce_d;
  logic             halted_q, halted_d;
  logic [BL_W-1:0]  bl_q, bl_d;
  logic [CNT_W-1:0] cc_q, cc_d;

  logic step_meta_q, step_sync_q, step_hist_q;
  logic step_pulse;
  logic tick;

  // Two-flop synchroniser plus a history flop. The edge detector runs in
  // every state, so a press outside IDLE is consumed and never queued.
  always_ff @(posedge inclk) begin
    if (rst) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_hist_q <= 1'b0;
    end else begin
      step_meta_q <= step_btn;
      step_sync_q <= step_meta_q;
      step_hist_q <= step_sync_q;
    end
  end

  assign step_pulse = step_sync_q & ~step_hist_q;
  assign tick       = (pre_q == PS_LAST);

  always_ff @(posedge inclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      ce_q     <= 1'b0;
      halted_q <= 1'b0;
      bl_q     <= '0;
      cc_q     <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      ce_q     <= ce_d;
      halted_q <= halted_d;
      bl_q     <= bl_d;
      cc_q     <= cc_d;
    end
  end

  // The prescaler defaults to 0 and only advances on the branches that stay
  // in RUN/BURST. Entering either mode therefore starts from 0, and the first
  // tick lands DIV cycles after entry. Any exit clears the count.
  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    ce_d    = 1'b0;
    bl_d    = bl_q;

    unique case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (run_sw) begin
          state_d = S_RUN;
        end else if (burst_go && (burst_len != '0)) begin
          state_d = S_BURST;
          bl_d    = burst_len;
        end else if (step_pulse) begin
          state_d = S_STEP;
          ce_d    = 1'b1;
        end
      end

      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (!run_sw) begin
          state_d = S_IDLE;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          ce_d  = tick;
        end
      end

      S_BURST: begin
        if (halt_req) begin
          state_d = S_HALT;
          bl_d    = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            ce_d = 1'b1;
            bl_d = bl_q - 1'b1;
            if (bl_q == BL_W'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_STEP: begin
        state_d = halt_req ? S_HALT : S_IDLE;
      end

      S_HALT: begin
        if (clr_halt && !halt_req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        bl_d    = '0;
      end
    endcase
  end

  always_comb begin
    halted_d = (state_d == S_HALT);
    cc_d     = ce_d ? cc_q + 1'b1 : cc_q;
  end

  assign proc_ce    = ce_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign burst_left = bl_q;
  assign cycle_cnt  = cc_q;

endmodule

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
Controller that sequences the processor clock-enable for bring-up and debug on the board.
- Supports four operating modes: free-run at a divided rate, single-step from a push button, N-cycle burst, and halt on processor request.
- Contains its own prescaler and produces one-inclk-wide enable pulses (proc_ce). The processor datapath stays on the single board clock.

Parameters:
DIV, 28'd50000000, inclk cycles per processor cycle in RUN/BURST (legal range ≥ 2)
BL_W, 8, width of burst length/counter
CNT_W, 16, width of executed-cycle counter

Ports:
inclk  input  1  board clock, only clock in the block
rst  input  1  reset, synchronous, active-high
run_sw  input  1  level; 1 requests free-run
step_btn  input  1  raw push button, asynchronous to inclk
burst_go  input  1  single-inclk pulse; starts a burst
burst_len  input  BL_W  burst length, sampled when burst_go is accepted
halt_req  input  1  level from processor (end/halt instruction)
clr_halt  input  1  single-inclk pulse; leave HALT
proc_ce  output  1  registered; one-inclk pulse per processor cycle
state  output  3  IDLE=0, RUN=1, BURST=2, STEP=3, HALT=4
halted  output  1  registered; 1 while in HALT
burst_left  output  BL_W  remaining burst cycles
cycle_cnt  output  CNT_W  number of proc_ce pulses issued, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at inclk edge):
  - state=IDLE; proc_ce=0; halted=0; burst_left=0; cycle_cnt=0.
  - Prescaler=0; step synchroniser flops=0.
  - Reset overrides everything, including mid-burst and mid-HALT.
- Step input path:
  - step_btn passes through a 2-flop synchroniser plus one history flop.
  - step_pulse = sync2 & ~hist, so each rising edge gives exactly one pulse and a held button never retriggers.
  - Edge detection runs in every state. A step_pulse outside IDLE is discarded, not queued.
- Prescaler:
  - Counts 0..DIV-1, only while state is RUN or BURST; held at 0 in all other states.
  - tick = (prescaler == DIV-1); the prescaler wraps to 0 on tick.
  - The first tick occurs DIV cycles after entering RUN or BURST.
- All outputs update on the same inclk edge as state. halt_req has highest priority in every non-HALT state.
- IDLE transitions (first match wins):
  - halt_req → HALT.
  - run_sw → RUN.
  - burst_go & burst_len≠0 → BURST, with burst_left<=burst_len.
  - step_pulse → STEP, with proc_ce<=1.
  - burst_go with burst_len=0 is ignored.
- RUN:
  - halt_req → HALT, no pulse issued even if tick.
  - Else !run_sw → IDLE, prescaler cleared.
  - Else on tick, proc_ce<=1.
- BURST:
  - halt_req → HALT, burst_left<=0.
  - Else on tick: proc_ce<=1 and burst_left<=burst_left-1; if burst_left==1 → IDLE.
  - run_sw, step_pulse and burst_go are ignored. N requested cycles yield exactly N pulses.
- STEP: lasts exactly one inclk. proc_ce=1 during it; next edge → IDLE with proc_ce<=0. halt_req is honoured on that edge (→ HALT).
- HALT:
  - halted=1, proc_ce=0.
  - clr_halt & !halt_req → IDLE.
  - clr_halt while halt_req is still high is ignored.
- proc_ce defaults to 0 on every edge not listed above, so it is never high for two consecutive cycles when DIV ≥ 2.
- cycle_cnt increments on the same edge proc_ce is set to 1, and wraps modulo 2^CNT_W with no flag.

Test Plan:
1. DIV=4, reset, run_sw=1 for 20 cycles → first proc_ce 4 cycles after RUN entry, then every 4 cycles; cycle_cnt=4 or 5 consistent with pulse count; run_sw=0 → IDLE next edge, prescaler 0.
2. DIV=4, burst_len=3, burst_go pulse → burst_left 3→2→1→0, exactly 3 proc_ce pulses 4 cycles apart, return to IDLE on third tick; burst_len=0 with burst_go → stays IDLE.
3. step_btn held high 50 cycles, then low, then high again → exactly two single-cycle proc_ce pulses, each 3–4 cycles after the button edge; step presses during RUN → no extra pulses.
4. halt_req asserted during BURST on a tick cycle → HALT, no proc_ce, burst_left=0, halted=1; clr_halt while halt_req=1 → stays HALT; halt_req=0 then clr_halt → IDLE.
5. rst asserted mid-RUN and mid-HALT → all outputs return to reset values on the next edge; cycle_cnt preloaded near 16'hFFFF via long RUN → wraps to 0.
